// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register carrying a control bundle
// and a data bundle over a valid/ready handshake. It has an optional
// one-entry skid register, so in_ready can come straight from a flop. It
// also has a synchronous flush that inserts a bubble, and a saturating
// counter of flush cycles that discarded live entries.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 24,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int ENT_W = CTRL_W + DATA_W;

    // The state encoding equals the number of held entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [ENT_W-1:0] r_m;
    logic [ENT_W-1:0] w_m_nxt;
    logic [ENT_W-1:0] r_s;
    logic [ENT_W-1:0] w_s_nxt;
    logic [ENT_W-1:0] w_in_ent;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [2:0]       w_kept;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_in_ent   = {in_ctrl, in_data};
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign occupancy  = r_state;
    assign drop_cnt   = r_drop_cnt;

    // M is cleared whenever the stage drains, so it reads as zero when idle.
    assign out_ctrl = r_m[ENT_W-1:DATA_W];
    assign out_data = r_m[DATA_W-1:0];

    // Entries that would still be held after this edge if no flush occurred.
    // out_fire implies at least one held entry, so this cannot underflow.
    assign w_kept = {1'b0, r_state} + {2'b00, w_in_fire} - {2'b00, w_out_fire};

    generate
        if (SKID != 0) begin : g_rdy_reg
            // Ready depends only on registered state; out_ready never reaches it.
            assign in_ready = (r_state != ST_FULL);
        end else begin : g_rdy_comb
            // Without a skid slot, accept only if M is empty or draining now.
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Next-state and register-load selection; flush overrides all handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_s_nxt     = r_s;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_m_nxt     = '0;
            w_s_nxt     = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_m_nxt     = w_in_ent;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_m_nxt = w_in_ent;
                    end else if (w_in_fire && (SKID != 0)) begin
                        w_s_nxt     = w_in_ent;
                        w_state_nxt = ST_FULL;
                    end else if (w_out_fire) begin
                        w_m_nxt     = '0;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_m_nxt     = r_s;
                        w_s_nxt     = '0;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_m_nxt     = '0;
                    w_s_nxt     = '0;
                end
            endcase
        end
    end

    // State and main register update, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_m     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Skid register holds the second entry while downstream is stalled.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s <= '0;
                end else begin
                    r_s <= w_s_nxt;
                end
            end
        end else begin : g_no_skid
            assign r_s = '0;
        end
    endgenerate

    // Count flush cycles that threw away at least one entry, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (flush && (w_kept != 3'd0) && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus pushes expected
// entries into a queue, and a negedge monitor pops and compares them on every
// out_fire. The monitor also checks idle zeroing and hold stability.
module tb_pipe_stage_skid;

    localparam int DW    = 96;
    localparam int CW    = 24;
    localparam int CNTW  = 2;
    localparam int ENT_W = DW + CW;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   in_ctrl;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_ctrl;
    logic [DW-1:0]   out_data;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [ENT_W-1:0] exp_q[$];

    pipe_stage_skid #(
        .DATA_W(DW),
        .CTRL_W(CW),
        .SKID  (1),
        .CNT_W (CNTW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [ENT_W-1:0] ent(input int k);
        logic [31:0] u;
        u = k;
        return {24'hA50000 | u[23:0], u ^ 32'h5A5A5A5A, ~u, u};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every out_fire pops the next expected entry.
    logic             prev_hold = 1'b0;
    logic [ENT_W-1:0] prev_ent  = '0;
    always @(negedge clk) begin
        logic [ENT_W-1:0] e;
        if (reset) begin
            if (prev_hold) begin
                chk("hold_valid", 128'(out_valid), 128'd1);
                chk("hold_stable", 128'({out_ctrl, out_data}), 128'(prev_ent));
            end
            if (!out_valid) begin
                chk("idle_zero", 128'({out_ctrl, out_data}), 128'd0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected none", {out_ctrl, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("out_order", 128'({out_ctrl, out_data}), 128'(e));
                end
            end
        end
        prev_hold = reset && out_valid && !out_ready && !flush;
        prev_ent  = {out_ctrl, out_data};
    end

    // One cycle of stimulus plus checks of the state held before the coming edge.
    task automatic step(input logic fl, input logic iv, input int k, input logic ordy,
                        input logic er, input logic [1:0] eocc, input logic [CNTW-1:0] edrop);
        @(posedge clk);
        #1;
        flush     = fl;
        in_valid  = iv;
        {in_ctrl, in_data} = iv ? ent(k) : '0;
        out_ready = ordy;
        @(negedge clk);
        #1;
        chk("in_ready", 128'(in_ready), 128'(er));
        chk("occupancy", 128'(occupancy), 128'(eocc));
        chk("drop_cnt", 128'(drop_cnt), 128'(edrop));
        if (fl) exp_q.delete();
        else if (iv && er) exp_q.push_back(ent(k));
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_ctrl = '0;
        in_data = '0;
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_occupancy", 128'(occupancy), 128'd0);
        chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        // Streaming at full rate.
        step(0, 1, 1, 1, 1, 0, 0);
        step(0, 1, 2, 1, 1, 1, 0);
        step(0, 1, 3, 1, 1, 1, 0);
        step(0, 1, 4, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        // Backpressure fills the skid slot, then drains in order.
        step(0, 1, 5, 0, 1, 0, 0);
        step(0, 1, 6, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 1, 0, 2, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        // Flush while full with a blocked incoming entry.
        step(0, 1, 7, 0, 1, 0, 0);
        step(0, 1, 8, 0, 1, 1, 0);
        step(1, 1, 9, 0, 0, 2, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        // Flush coinciding with delivery of the only entry.
        step(0, 1, 10, 1, 1, 0, 1);
        step(1, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        // Flush on an empty stage does not count.
        step(1, 0, 0, 1, 1, 0, 1);
        // Flush discarding an incoming entry, then saturation.
        step(1, 1, 11, 1, 1, 0, 1);
        step(0, 1, 12, 0, 1, 0, 2);
        step(1, 0, 0, 0, 1, 1, 2);
        step(0, 1, 13, 0, 1, 0, 3);
        step(1, 0, 0, 0, 1, 1, 3);
        step(0, 0, 0, 1, 1, 0, 3);
        // Asynchronous reset while full.
        step(0, 1, 14, 0, 1, 0, 3);
        step(0, 1, 15, 0, 1, 1, 3);
        @(posedge clk);
        #3;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_occupancy", 128'(occupancy), 128'd0);
        chk("arst_drop_cnt", 128'(drop_cnt), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_out_zero", 128'({out_ctrl, out_data}), 128'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        step(0, 1, 16, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised inter-stage pipeline register for the pipelined datapath, e.g. decode→execute or execute→memory.
Carries a control bundle and a data bundle with valid/ready handshake, synchronous flush and an optional one-entry skid buffer. Stalls propagate through the handshake, not through a global enable, so in_ready can be registered.
Flush is a synchronous bubble insertion. Asynchronous reset is kept separate from it.

Parameters:
DATA_W, 96, width of data bundle (e.g. RD1, RD2, extended immediate)
CTRL_W, 24, width of control bundle (regwrite, memwrite, ALU control, cond, flags, register addresses, …)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready combinational
CNT_W, 8, width of the discarded-entry counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous clear; inserts bubble, discards held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts entry this cycle
out_ctrl  out  CTRL_W  registered control bundle
out_data  out  DATA_W  registered data bundle
occupancy  out  2  number of valid entries held (0..2)
drop_cnt  out  CNT_W  saturating count of flush cycles that discarded ≥1 valid entry

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Latency 1 cycle in→out. Sustained throughput 1 entry/cycle when out_ready=1.
- State machine, SKID=1, with main register M and skid register S:
  - EMPTY (occ 0): in_fire → M<=in, ONE.
  - ONE (occ 1), out_valid=1:
    - in_fire & out_fire → M<=in, stay ONE.
    - in_fire & !out_fire → S<=in, FULL.
    - !in_fire & out_fire → M<=0, EMPTY.
    - Otherwise hold.
  - FULL (occ 2):
    - out_fire → M<=S, S<=0, ONE.
    - Otherwise hold.
  - in_ready = (state != FULL). It is derived from registered state only; there is no combinational path from out_ready.
- SKID=0:
  - No S register; FULL is unreachable.
  - in_ready = !out_valid | out_ready (combinational).
  - ONE with in_fire & out_fire → M<=in.
- Stability: while out_valid=1 and out_ready=0, out_ctrl/out_data do not change.
- When out_valid=0, out_ctrl and out_data are all-zero.
- Ordering: entries leave in arrival order; no entry is duplicated or lost except by flush.
- Flush (flush=1 at clock edge):
  - It has priority over all handshake activity.
  - Next state is EMPTY; M and S become 0; out_valid=0.
  - Any in_fire that cycle is discarded.
  - in_ready keeps its state-derived value during the flush cycle.
  - out_fire in the same cycle still counts as delivered downstream; it is not a drop.
- drop_cnt:
  - Increments by 1 on a flush cycle when occupancy>0 before the edge, or in_fire=1, not counting an entry consumed by out_fire that same cycle.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - State EMPTY; M, S = 0.
  - out_valid=0, occupancy=0, drop_cnt=0.
  - in_ready=1 while in reset and in the first cycle after release.
- Back-to-back flush cycles:
  - Each cycle is evaluated independently.
  - A flush on an empty stage with in_valid=0 does not change drop_cnt.

Test Plan:
- Stream: out_ready=1, in_valid=1 with in_data=1,2,3,4 over consecutive cycles → out_data=1,2,3,4 one cycle later each; occupancy stays 1; in_ready stays 1.
- Backpressure (SKID=1): entries A, B in, out_ready=0 → occupancy=2, in_ready=0, out_data=A held stable. Then raise out_ready → A, then B, in order; in_ready=1 the cycle after A leaves.
- Flush while FULL: hold A, B; flush=1 with in_valid=1 (C) → next cycle out_valid=0, out_ctrl=out_data=0, occupancy=0, drop_cnt=1; C never appears.
- Flush with simultaneous out_fire on a ONE-state stage with in_valid=0 → entry delivered, drop_cnt unchanged.
- Saturation: CNT_W=2, flush four times with occupancy=1 each time → drop_cnt=1,2,3,3.
- Async reset mid-stream: assert reset=0 between edges while FULL → out_valid=0, occupancy=0, drop_cnt=0 immediately, before the next clk edge. After release, the first input appears after 1 cycle.
